// File: rtl/fir_multichannel.sv
// Multichannel FIR filter: one delay line per channel, a shared coefficient table and one MAC.
// Build option: define FIR_SATURATE_EN to clamp the output instead of wrapping it.
module fir_multichannel #(
    parameter int WIDTH  = 32,
    parameter int NCOEFS = 10,
    parameter int NCHAN  = 4,
    parameter int CWIDTH = 16,
    parameter int FRAC   = 8,
    localparam int CH    = (NCHAN > 1) ? $clog2(NCHAN) : 1,
    localparam int AW    = $clog2(NCOEFS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [CH-1:0]     in_chan,
    input  logic              coef_we,
    input  logic [AW-1:0]     coef_addr,
    input  logic [CWIDTH-1:0] coef_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [CH-1:0]     out_chan
);

    // state | meaning
    // IDLE  | waiting for a sample; coefficient writes allowed
    // MAC   | one tap product per cycle, accumulated one cycle later
    // OUT   | result presented until downstream accepts it

    localparam int PW   = WIDTH + CWIDTH;
    localparam int ACCW = PW + AW;
    localparam int CW   = $clog2(NCOEFS + 1);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t state, state_nxt;

    logic signed [WIDTH-1:0]  taps [NCHAN][NCOEFS];
    logic signed [CWIDTH-1:0] coefs [NCOEFS];
    logic [CH-1:0]            chan_q;
    logic [CW-1:0]            cnt;
    logic signed [PW-1:0]     prod;
    logic signed [ACCW-1:0]   acc;
    logic signed [ACCW-1:0]   acc_sum;
    logic [AW-1:0]            idx;
    logic [WIDTH-1:0]         tap_sel;
    logic [CWIDTH-1:0]        coef_sel;
    logic [WIDTH-1:0]         result;
    logic [WIDTH-1:0]         out_data_q;
    logic                     accept;
    logic                     chan_ok;
    logic                     coef_ok;

    assign accept   = in_valid && in_ready;
    assign chan_ok  = int'(in_chan) < NCHAN;
    assign coef_ok  = coef_we && (state == IDLE) && (int'(coef_addr) < NCOEFS);
    assign idx      = AW'(cnt - CW'(1));
    assign tap_sel  = taps[chan_q][idx];
    assign coef_sel = coefs[idx];
    // The product register delays each term by one cycle, so the sum is complete when cnt hits 0.
    assign acc_sum  = acc + {{AW{prod[PW-1]}}, prod};

`ifdef FIR_SATURATE_EN
    localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [ACCW-1:0] acc_shr;

    assign acc_shr = acc_sum >>> FRAC;

    always_comb begin
        result = acc_shr[WIDTH-1:0];
        if (acc_shr[ACCW-1:WIDTH-1] != {(ACCW-WIDTH+1){acc_shr[ACCW-1]}})
            result = acc_shr[ACCW-1] ? MINV : MAXV;
    end
`else
    assign result = WIDTH'(acc_sum >>> FRAC);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && chan_ok)
                    state_nxt = MAC;
            end
            MAC: begin
                if (cnt == '0)
                    state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < NCHAN; ch++)
                for (int k = 0; k < NCOEFS; k++)
                    taps[ch][k] <= '0;
            for (int k = 0; k < NCOEFS; k++)
                coefs[k] <= '0;
            chan_q     <= '0;
            cnt        <= '0;
            prod       <= '0;
            acc        <= '0;
            out_data_q <= '0;
        end else begin
            if (coef_ok)
                coefs[coef_addr] <= coef_data;
            if (accept && chan_ok) begin
                for (int ch = 0; ch < NCHAN; ch++) begin
                    if (in_chan == CH'(ch)) begin
                        taps[ch][0] <= in_data;
                        for (int k = 1; k < NCOEFS; k++)
                            taps[ch][k] <= taps[ch][k-1];
                    end
                end
                chan_q <= in_chan;
                cnt    <= CW'(NCOEFS);
                prod   <= '0;
                acc    <= '0;
            end
            if (state == MAC) begin
                acc <= acc_sum;
                if (cnt != '0) begin
                    prod <= $signed({{CWIDTH{tap_sel[WIDTH-1]}}, tap_sel})
                          * $signed({{WIDTH{coef_sel[CWIDTH-1]}}, coef_sel});
                    cnt  <= cnt - CW'(1);
                end else begin
                    out_data_q <= result;
                end
            end
        end
    end

    assign out_data = out_data_q;
    assign out_chan = chan_q;

endmodule
